lut_write_sequencer: RTL

- Sequences user-mode rewrites of a fracturable dual-LUT (two INPUTS-input LUTs sharing one 2*INPUTS-bit address bus, single-bit write port, per-LUT select).
- Accepts a full MEM_SIZE-bit truth table for one LUT over a valid/ready handshake and serialises it into MEM_SIZE single-bit writes.
- Owns the LUT address bus: passes user_addr through when idle and drives it from an internal counter while writing.
- Sits between the CLB user-write interface and the LUT pair.

---
 rtl/lut_write_sequencer.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/lut_write_sequencer.sv
// lut_write_sequencer: serialises a full truth table for one LUT of a fracturable
// dual-LUT pair into single-bit writes, owning the shared LUT address bus while busy.
//
// Ports:
//   clk, rst             clock (shared with the LUT write port), async active-high reset
//   req_valid/req_ready  request handshake; req_lut_sel picks the LUT (1 = first)
//   req_data             truth table, bit k goes to entry k
//   split_mode           live fracture setting of the LUT pair (1 = split)
//   user_addr            fabric address, passed to lut_addr when not sequencing
//   lut_addr, lut_data_in, lut_write_en, lut_write_lut_select   LUT write port
//   lut_out              LUT pair outputs, used only for readback
//   busy, done, err      status; done/err are one-cycle pulses
//
// Build option: define LUT_WRITE_READBACK_EN to add a VERIFY pass that reads the
// table back after writing and flags mismatches with err alongside done.
module lut_write_sequencer #(
  parameter int unsigned INPUTS   = 4,
  parameter int unsigned MEM_SIZE = 2 ** INPUTS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_lut_sel,
  input  logic [MEM_SIZE-1:0]   req_data,
  input  logic                  split_mode,
  input  logic [2*INPUTS-1:0]   user_addr,
  output logic [2*INPUTS-1:0]   lut_addr,
  output logic                  lut_data_in,
  output logic                  lut_write_en,
  output logic                  lut_write_lut_select,
  input  logic [1:0]            lut_out,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int unsigned AW = 2 * INPUTS;

  typedef enum logic [1:0] {
    StIdle,
    StWrite,
    StDone
`ifdef LUT_WRITE_READBACK_EN
    , StVerify
`endif
  } state_e;

  state_e                state_q, state_d;
  logic [INPUTS-1:0]     idx_q, idx_d;
  logic [MEM_SIZE-1:0]   data_q;
  logic                  sel_q;
  logic                  err_q, err_d;
  logic                  accept, reject, abort, last;
  logic [AW-1:0]         walk_addr;
  logic                  rb_err;

  assign accept = req_valid && (state_q == StIdle);
  // The second LUT's top address bit is only reachable when the pair is split.
  assign reject = accept && !req_lut_sel && !split_mode;
  assign abort  = (state_q == StWrite) && !sel_q && !split_mode;
  assign last   = (idx_q == INPUTS'(MEM_SIZE - 1));

  // First LUT sits on the upper address half; the second LUT uses the lower half
  // with its top entry bit routed to lut_addr[INPUTS] and lut_addr[INPUTS-1] held 0.
  always_comb begin
    walk_addr = '0;
    if (sel_q) begin
      walk_addr[AW-1:INPUTS] = idx_q;
    end else begin
      walk_addr[INPUTS]       = idx_q[INPUTS-1];
      walk_addr[INPUTS-2:0]   = idx_q[INPUTS-2:0];
    end
  end

`ifdef LUT_WRITE_READBACK_EN
  logic                tail_q;
  logic                cmp_q;
  logic [INPUTS-1:0]   vidx_q;
  logic                flag_q;

  // LUT read data lags the driven address by one cycle, so compares run one
  // cycle behind idx; tail_q adds the extra cycle for the final compare.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tail_q <= 1'b0;
      cmp_q  <= 1'b0;
      vidx_q <= '0;
      flag_q <= 1'b0;
    end else begin
      tail_q <= (state_q == StVerify) && !tail_q && last;
      cmp_q  <= (state_q == StVerify) && !tail_q;
      vidx_q <= idx_q;
      if (accept) begin
        flag_q <= 1'b0;
      end else if (cmp_q && (lut_out[sel_q] != data_q[vidx_q])) begin
        flag_q <= 1'b1;
      end
    end
  end

  assign rb_err = flag_q;
`else
  logic unused_lut_out;
  assign unused_lut_out = ^lut_out;
  assign rb_err         = 1'b0;
`endif

  always_comb begin
    state_d              = state_q;
    idx_d                = idx_q;
    err_d                = 1'b0;
    req_ready            = 1'b0;
    busy                 = 1'b0;
    done                 = 1'b0;
    lut_addr             = user_addr;
    lut_data_in          = 1'b0;
    lut_write_en         = 1'b0;
    lut_write_lut_select = 1'b0;
    err                  = err_q;
    unique case (state_q)
      StIdle: begin
        req_ready = 1'b1;
        if (accept) begin
          if (reject) begin
            err_d = 1'b1;
          end else begin
            state_d = StWrite;
            idx_d   = '0;
          end
        end
      end
      StWrite: begin
        busy                 = 1'b1;
        lut_addr             = walk_addr;
        lut_data_in          = data_q[idx_q];
        lut_write_lut_select = sel_q;
        if (abort) begin
          // Fracture lost under a second-LUT write: stop without writing this entry.
          err_d   = 1'b1;
          state_d = StIdle;
          idx_d   = '0;
        end else begin
          lut_write_en = 1'b1;
          if (last) begin
`ifdef LUT_WRITE_READBACK_EN
            state_d = StVerify;
            idx_d   = '0;
`else
            state_d = StDone;
`endif
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
`ifdef LUT_WRITE_READBACK_EN
      StVerify: begin
        busy     = 1'b1;
        lut_addr = walk_addr;
        if (tail_q) begin
          state_d = StDone;
        end else if (!last) begin
          idx_d = idx_q + 1'b1;
        end
      end
`endif
      StDone: begin
        busy    = 1'b1;
        done    = 1'b1;
        err     = err_q | rb_err;
        state_d = StIdle;
        idx_d   = '0;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      data_q  <= '0;
      sel_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      if (accept) begin
        data_q <= req_data;
        sel_q  <= req_lut_sel;
      end
    end
  end

endmodule
